// File: rtl/adc_ram_drain.sv
// Drains adc_capture's sample ring through the RAM's second read port and emits
// the words as a packetised valid/ready stream with overflow and sequence flags.
module adc_ram_drain #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int PKT_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear_flags,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              cap_we,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow,
    output logic              seq_err
);

    localparam int              CNT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [ADDR_W:0] FULL      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   fill;
    logic              ovf_q;
    logic              seq_q;
    logic              inflight;
    logic [DATA_W-1:0] fifo [2];
    logic              wr_idx;
    logic              rd_idx;
    logic [1:0]        occ;
    logic [CNT_W-1:0]  beat;

    logic              pop;
    logic              issue;
    logic [2:0]        slots;

    always_comb begin
        pop   = (occ != 2'd0) & m_ready;
        slots = {1'b0, occ} + {2'b00, inflight};
        issue = enable & (fill != '0) & (slots < (3'd2 + {2'b00, pop}));
    end

    assign ram_rd_en   = issue;
    assign ram_rd_addr = rd_ptr;
    assign m_valid     = (occ != 2'd0);
    assign m_data      = fifo[rd_idx];
    assign m_last      = m_valid & (beat == LAST_BEAT);
    assign fill_level  = fill;
    assign overflow    = ovf_q;
    assign seq_err     = seq_q;

    // The write strobe is registered once before accounting, so a word is only
    // requested a full cycle after the RAM committed it (3-clock we->m_valid).
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            exp_addr <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            ovf_q    <= 1'b0;
            seq_q    <= 1'b0;
            inflight <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            occ      <= 2'd0;
            beat     <= '0;
        end else begin
            we_q   <= cap_we;
            addr_q <= cap_addr;

            if (we_q && !issue) begin
                if (fill != FULL)
                    fill <= fill + (ADDR_W+1)'(1);
            end else if (issue && !we_q) begin
                fill <= fill - (ADDR_W+1)'(1);
            end

            if (we_q && !issue && (fill == FULL))
                ovf_q <= 1'b1;
            else if (clear_flags)
                ovf_q <= 1'b0;

            if (we_q && (addr_q != exp_addr))
                seq_q <= 1'b1;
            else if (clear_flags)
                seq_q <= 1'b0;

            if (we_q)
                exp_addr <= addr_q + ADDR_W'(1);

            if (issue)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            inflight <= issue;

            if (inflight) begin
                fifo[wr_idx] <= ram_rd_data;
                wr_idx       <= ~wr_idx;
            end

            if (pop) begin
                rd_idx <= ~rd_idx;
                beat   <= (beat == LAST_BEAT) ? '0 : beat + CNT_W'(1);
            end

            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_ram_drain.sv
// Directed bench for adc_ram_drain: RAM model, stream scoreboard and flag checks.
module tb_adc_ram_drain;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int PKT_LEN = 64;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              clear_flags;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [DATA_W-1:0] cap_wdata;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [ADDR_W:0]   fill_level;
    logic              overflow;
    logic              seq_err;

    adc_ram_drain #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PKT_LEN(PKT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear_flags(clear_flags),
        .cap_addr   (cap_addr),
        .cap_we     (cap_we),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .fill_level (fill_level),
        .overflow   (overflow),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Dual-port RAM: written by the capture side, second port read with 1-cycle latency
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (cap_we) mem[cap_addr] <= cap_wdata;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] popped[$];
    logic [DATA_W-1:0] wr_log[$];
    logic [ADDR_W-1:0] exp_rd;
    int                outstanding, pop_cnt, last_cnt, wrap_seen, beat;
    int                first_pop_cyc, last_pop_cyc;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    logic              rand_ready;

    task automatic clear_model();
        exp_q.delete();
        popped.delete();
        wr_log.delete();
        exp_rd      = '0;
        outstanding = 0;
        pop_cnt     = 0;
        last_cnt    = 0;
        wrap_seen   = 0;
        beat        = 0;
        prev_stall  = 1'b0;
    endtask

    // Stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            check("m_last", m_last, m_valid && (beat == PKT_LEN - 1));
            if (ram_rd_en) begin
                check("rd_en_gate", enable, 1);
                check("rd_addr", ram_rd_addr, exp_rd);
                if (!(m_valid && m_ready)) check("issue_room", outstanding < 2, 1);
                if (exp_rd == ADDR_W'(DEPTH - 1)) wrap_seen++;
                exp_q.push_back(mem[exp_rd]);
                exp_rd = exp_rd + 1'b1;
                outstanding++;
            end
            if (m_valid && m_ready) begin
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    d = exp_q.pop_front();
                    check("m_data", m_data, d);
                end
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                popped.push_back(m_data);
                pop_cnt++;
                outstanding--;
                if (m_last) last_cnt++;
                beat = (beat == PKT_LEN - 1) ? 0 : beat + 1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic do_write(input int addr, input logic [DATA_W-1:0] data);
        cap_addr  = ADDR_W'(addr);
        cap_wdata = data;
        cap_we    = 1'b1;
        wr_log.push_back(data);
        tick();
        cap_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        clear_model();
        rst = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
    endtask

    task automatic wait_pops(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && pop_cnt < target; i++) tick();
        check(tag, pop_cnt, target);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 2ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; clear_flags = 1'b0;
        cap_addr = '0; cap_we = 1'b0; cap_wdata = '0;
        m_ready = 1'b1; rand_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear_model();

        // Reset held with the write strobe toggling
        for (int i = 0; i < 3; i++) begin
            cap_we   = (i % 2 == 0);
            cap_addr = 12'h055;
            tick();
            check("rst_valid", m_valid, 0);
            check("rst_rd_en", ram_rd_en, 0);
            check("rst_ovf", overflow, 0);
            check("rst_seq", seq_err, 0);
            check("rst_fill", fill_level, 0);
        end
        cap_we = 1'b0;
        clear_model();
        rst = 1'b0;

        // First write after reset: m_valid exactly 3 clocks later
        do_write(0, 32'h0000_00A0);
        check("lat_k0", m_valid, 0);
        tick(); check("lat_k1", m_valid, 0);
        tick(); check("lat_k2", m_valid, 0);
        tick(); check("lat_k3", m_valid, 1);
        wait_pops("lat_pop", 1, 20);

        // Basic drain
        do_reset();
        for (int i = 0; i < 8; i++) do_write(i, 32'h100 + i);
        wait_pops("basic_cnt", 8, 30);
        check("basic_rate", last_pop_cyc - first_pop_cyc, 7);
        for (int i = 0; i < 8; i++) check("basic_data", popped[i], 32'h100 + i);
        tick();
        check("basic_fill", fill_level, 0);

        // Backpressure with random ready
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) do_write(i, $urandom);
        wait_pops("bp_cnt", 200, 5000);
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        for (int i = 0; i < 200; i++) check("bp_order", popped[i], wr_log[i]);
        check("bp_q_empty", exp_q.size(), 0);

        // Ring wrap and packet boundaries
        do_reset();
        for (int i = 0; i < 4100; i++) do_write(i % DEPTH, 32'h5A5A_0000 ^ i);
        wait_pops("wrap_cnt", 4100, 200);
        check("wrap_last_cnt", last_cnt, 64);
        check("wrap_addr_seen", wrap_seen != 0, 1);
        check("wrap_seq", seq_err, 0);
        check("wrap_fill", fill_level, 0);
        check("wrap_order_hi", popped[4099], wr_log[4099]);
        check("wrap_order_lo", popped[4095], wr_log[4095]);

        // Overflow with reads disabled
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_write(i, 32'hC000_0000 + i);
        tick();
        check("ovf_full_fill", fill_level, DEPTH);
        check("ovf_not_yet", overflow, 0);
        do_write(0, 32'hDEAD_0000);
        tick();
        check("ovf_sat_fill", fill_level, DEPTH);
        check("ovf_set", overflow, 1);
        pulse_clear();
        check("ovf_cleared", overflow, 0);
        enable = 1'b1;
        wait_pops("ovf_drain", DEPTH, 4300);
        repeat (5) tick();
        check("ovf_drain_total", pop_cnt, DEPTH);
        check("ovf_fill_empty", fill_level, 0);

        // Sequence error, resync, set-wins-over-clear
        do_reset();
        for (int i = 0; i < 6; i++) do_write(i, 32'h500 + i);
        do_write(9, 32'h509);
        tick();
        check("seq_set", seq_err, 1);
        pulse_clear();
        check("seq_clear", seq_err, 0);
        do_write(10, 32'h50A);
        tick();
        check("seq_resync", seq_err, 0);
        cap_addr = 12'd20; cap_wdata = 32'h514; cap_we = 1'b1;
        tick();
        cap_we = 1'b0;
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("seq_set_wins", seq_err, 1);
        wait_pops("seq_drain", 9, 40);

        // Mid-stream reset with buffered words
        m_ready = 1'b0;
        for (int i = 21; i < 25; i++) do_write(i, 32'h600 + i);
        repeat (4) tick();
        check("mid_valid_before", m_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_valid", m_valid, 0);
        check("mid_fill", fill_level, 0);
        check("mid_rd_addr", ram_rd_addr, 0);
        check("mid_rd_en", ram_rd_en, 0);
        check("mid_last", m_last, 0);
        check("mid_seq", seq_err, 0);
        m_ready = 1'b1;
        tick();
        clear_model();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_quiet", m_valid, 0);
        end
        do_write(0, 32'h0000_0777);
        wait_pops("mid_restart", 1, 20);
        check("mid_restart_data", popped[0], 32'h0000_0777);
        check("mid_restart_seq", seq_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_ram_drain.md
Name: adc_ram_drain

Overview:
- Downstream consumer of adc_capture's sample RAM. It tracks adc_capture's write port (address and write-enable) to learn how many words are captured but not yet read.
- It reads those words through the RAM's second read port (1-cycle latency) in ring order.
- It emits them as a valid/ready stream, packetised with a last flag, toward the JTAG readout path.
- It flags writer-laps-reader overflow and non-sequential writer addresses.

Parameters:
ADDR_W, 12, RAM address width; ring depth DEPTH = 2^ADDR_W words
DATA_W, 32, RAM/stream word width
PKT_LEN, 64, beats per packet; m_last on final beat (range 1..DEPTH)

Ports:
clk  in  1  single clock, same domain as adc_capture
rst  in  1  synchronous, active-high reset
enable  in  1  1 = may issue new RAM reads
clear_flags  in  1  1-cycle pulse, clears overflow and seq_err
cap_addr  in  ADDR_W  adc_capture write address (adc_ram_addr)
cap_we  in  1  adc_capture write strobe (adc_ram_we)
ram_rd_en  out  1  read request this cycle
ram_rd_addr  out  ADDR_W  read address (= rd_ptr)
ram_rd_data  in  DATA_W  read data, valid exactly 1 cycle after ram_rd_en
m_data  out  DATA_W  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  last beat of packet
fill_level  out  ADDR_W+1  words written but not yet requested, 0..DEPTH
overflow  out  1  sticky: writer lapped reader
seq_err  out  1  sticky: cap_addr not sequential

Behaviour:
- Reset: all outputs 0; rd_ptr=0, exp_addr=0, fill=0, beat counter=0, FIFO empty, in-flight cleared. Reset mid-operation discards in-flight and buffered data; no beat is emitted on the cycle after rst.
- Fill accounting:
  - cap_we & !ram_rd_en: fill+1.
  - ram_rd_en & !cap_we: fill-1.
  - Both together: unchanged.
- Overflow: cap_we with fill==DEPTH and no ram_rd_en sets overflow=1. fill saturates at DEPTH. Draining continues; data integrity is not guaranteed after overflow.
- Sequence check:
  - On cap_we, cap_addr != exp_addr sets seq_err=1.
  - exp_addr <= cap_addr+1 (mod DEPTH) on every cap_we, resyncing to the writer.
  - rd_ptr does not resync.
- Flag clearing: clear_flags clears both sticky flags. If a set condition occurs in the same cycle, the set wins.
- Output buffer: 2-entry FIFO plus a 1-bit in-flight flag.
- Read issue: ram_rd_en = enable & fill>0 & (occ + inflight - pop) < 2, where pop = m_valid & m_ready.
  - ram_rd_en is combinational from registered state and m_ready.
  - On issue: rd_ptr+1 (wraps DEPTH-1 -> 0), inflight<=1.
  - The next cycle, ram_rd_data is pushed into the FIFO.
- Stream output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Sustained throughput is 1 beat/clk with m_ready=1.
  - No word is lost or duplicated under any m_ready pattern.
  - m_data and m_last hold stable while m_valid & !m_ready.
- Latency: cap_we sampled at edge k -> ram_rd_en high during cycle k+1 -> m_valid high after edge k+3 (3 clocks).
- enable=0: stops new reads only; in-flight and buffered words still drain.
- Packetising: beat counter increments on pop, wraps at PKT_LEN-1 -> 0. m_last = m_valid & (counter==PKT_LEN-1). PKT_LEN=1 gives m_last on every beat.
- Arithmetic: all address arithmetic is modulo DEPTH; fill is ADDR_W+1 bits, unsigned.

Test Plan:
- Reset: hold rst 3 clks with cap_we toggling -> m_valid, ram_rd_en, overflow, seq_err, fill_level all 0. First m_valid 3 clks after the first post-reset cap_we.
- Basic drain: RAM model preloaded mem[i]=i+0x100; cap_we 8 times at addr 0..7; m_ready=1 -> 8 beats 0x100..0x107 in order, 1 per clk, fill_level returns to 0.
- Backpressure: 200 words with m_ready random 30% duty -> exact order, no duplicates; ram_rd_en never issues with occ+inflight==2 and no pop; m_data stable while stalled.
- Wrap and packets: 4100 sequential writes (addr 4095 -> 0), PKT_LEN=64, m_ready=1 -> ram_rd_addr wraps 4095 -> 0; m_last on beats 63, 127, …, 4095; seq_err stays 0.
- Overflow: enable=0, 4097 writes -> fill_level 4096, overflow=1 after the 4097th. clear_flags -> overflow=0. Then enable=1 -> 4096 beats drain.
- Sequence error/mid-op reset: writes 0..5 then cap_addr=9 -> seq_err=1, next expected 10. Assert rst during streaming -> m_valid=0 the next clk and counters zeroed.
